nios2_ocimem_arbiter: RTL and testbench
=======================================

# nios2_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (OCI RAM) between two requesters: the JTAG debug command path and the CPU's Avalon debug-slave port. It sits between the debug-slave decode logic (clk-domain action pulses) and a single-port, 1-cycle-latency OCI RAM. It owns the JTAG auto-incrementing address register, round-robin / debug-priority arbitration, and the Avalon waitrequest handshake.

## Interface
- ADDR_W, 8: OCI RAM word-address width.
- DATA_W, 32: data width; byte enables are DATA_W/8 wide.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- debugack  in  1  CPU in debug mode; gives JTAG strict priority.
- jcmd_valid  in  1  one-cycle JTAG command pulse.
- jcmd_setaddr  in  1  qualifies jcmd_valid: load address only, no RAM access.
- jcmd_write  in  1  qualifies jcmd_valid: 1 = write, 0 = read.
- jcmd_addr  in  ADDR_W  address for setaddr.
- jcmd_wdata  in  DATA_W  write data.
- jcmd_ready  out  1  no JTAG access pending.
- jrsp_valid  out  1  one-cycle completion pulse.
- jrsp_rdata  out  DATA_W  last JTAG read data; holds value between reads.
- jerr  out  1  sticky: a command was dropped.
- av_address  in  ADDR_W; av_read, av_write  in  1; av_writedata  in  DATA_W; av_byteenable  in  DATA_W/8.
- av_readdata  out  DATA_W; av_waitrequest  out  1.
- ram_addr  out  ADDR_W; ram_we  out  1; ram_be  out  DATA_W/8; ram_wdata  out  DATA_W.
- ram_rdata  in  DATA_W: RAM read data, valid one cycle after the address is presented.

## Operation
- States: IDLE, J_ACC, J_RD, A_ACC, A_RD.
- JTAG setaddr:
  - jaddr <= jcmd_addr in the same edge.
  - No arbitration; accepted in any state.
- JTAG read or write:
  - Accepted only when jpend = 0. The command sets jpend and latches write and wdata.
  - If jpend = 1, the command is dropped and jerr is set.
  - jcmd_ready = !jpend.
- Avalon request: av_read | av_write. The master holds all av_* signals stable while av_waitrequest = 1.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending and debugack = 1: grant JTAG.
  - Both pending and debugack = 0: grant the requester not granted last (last_grant reset = Avalon, so JTAG wins the first tie).
- J_ACC:
  - ram_addr = jaddr, ram_be = all ones, ram_wdata = latched wdata, ram_we = write.
  - Write: pulse jrsp_valid, then go to IDLE.
  - Read: go to J_RD.
  - Either way: clear jpend and set jaddr <= jaddr + 1, wrapping 2^ADDR_W-1 to 0.
- J_RD: jrsp_rdata <= ram_rdata, pulse jrsp_valid, go to IDLE.
- A_ACC:
  - ram_* driven from av_*.
  - Write: av_waitrequest = 0, go to IDLE.
  - Read: go to A_RD.
- A_RD: av_readdata = ram_rdata, av_waitrequest = 0, go to IDLE.
- IDLE and J_* states drive ram_we = 0 except as stated above, and ram_addr = 0 in IDLE.
- Reset values:
  - State IDLE; jpend 0; jaddr 0; jerr 0; jrsp_valid 0; jrsp_rdata 0; last_grant Avalon.
  - av_waitrequest 1, ram_we 0.
- Reset mid-access: the access is abandoned. No jrsp_valid is issued, and an uncommitted write never reaches the RAM.

## Timing
- JTAG write, pulse in cycle 0:
  - Cycle 1: IDLE with jpend = 1.
  - Cycle 2: J_ACC; RAM written and jrsp_valid = 1.
  - Cycle 3: jcmd_ready = 1.
- JTAG read: J_RD in cycle 3 with jrsp_valid = 1; jrsp_rdata is valid from cycle 4.
- Avalon write: request in cycle 0 (IDLE); A_ACC in cycle 1 with waitrequest = 0. Two cycles minimum.
- Avalon read: A_RD in cycle 2 with waitrequest = 0 and readdata valid. Three cycles minimum.
- Contention adds at most one full access of the other requester when debugack = 0.
- Setaddr and read/write in the same cycle: setaddr wins. The read/write qualifier is ignored.
- av_waitrequest is a function of state only. It is never low in IDLE.

## Structure
- Shared package nios2_ocimem_pkg holds:
  - the state enum;
  - the grant encoding (GRANT_JTAG / GRANT_AV);
  - default ADDR_W and DATA_W constants.
- One natural sub-module, nios2_ocimem_jtag_cmd, owns jaddr, jpend, the latched command, jerr, and the increment/wrap logic. The FSM and muxing stay in the top.

## Test plan
- JTAG setaddr 0x10, write 0xDEADBEEF, setaddr 0x10, read:
  - jrsp_rdata = 0xDEADBEEF.
  - jaddr = 0x11 after the read.
  - Write completes in cycle 2 and the read's jrsp_valid is in cycle 3.
- Setaddr 0xFF then two writes: data lands at 0xFF then 0x00 (wrap).
- Avalon write 0x5 to address 0x20 with byteenable 0b0011, then a read:
  - waitrequest low for exactly one cycle each.
  - Readdata low half = 0x0005, upper half unchanged.
- Simultaneous JTAG write and Avalon write:
  - debugack = 0: JTAG first, Avalon granted next. Then alternates on repeated ties.
  - debugack = 1: JTAG always first.
- Second JTAG read pulse while jpend = 1: dropped, jerr = 1 and stays set, only one jrsp_valid.
- Reset asserted in J_ACC of a write: no RAM write, no jrsp_valid, and all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/nios2_ocimem_pkg.sv
// rtl/nios2_ocimem_pkg.sv - shared types and default widths for the OCI RAM arbiter
package nios2_ocimem_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_ACC,
        ST_J_RD,
        ST_A_ACC,
        ST_A_RD
    } state_t;

    typedef enum logic {
        GRANT_JTAG = 1'b0,
        GRANT_AV   = 1'b1
    } grant_t;
endpackage

// File: rtl/nios2_ocimem_jtag_cmd.sv
// rtl/nios2_ocimem_jtag_cmd.sv - JTAG auto-increment address, pending command latch and drop flag
module nios2_ocimem_jtag_cmd
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_setaddr,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic              i_consume,
    output logic [ADDR_W-1:0] o_jaddr,
    output logic              o_jpend,
    output logic              o_write,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_jerr
);
    logic [ADDR_W-1:0] r_jaddr;
    logic              r_jpend;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_jerr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_jaddr <= '0;
            r_jpend <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_jerr  <= 1'b0;
        end else begin
            if (i_consume) begin
                r_jpend <= 1'b0;
                r_jaddr <= r_jaddr + ADDR_W'(1);
            end
            // An explicit setaddr overrides the post-access increment.
            if (i_cmd_valid && i_cmd_setaddr) begin
                r_jaddr <= i_cmd_addr;
            end else if (i_cmd_valid) begin
                if (r_jpend) begin
                    r_jerr <= 1'b1;
                end else begin
                    r_jpend <= 1'b1;
                    r_write <= i_cmd_write;
                    r_wdata <= i_cmd_wdata;
                end
            end
        end
    end

    assign o_jaddr = r_jaddr;
    assign o_jpend = r_jpend;
    assign o_write = r_write;
    assign o_wdata = r_wdata;
    assign o_jerr  = r_jerr;
endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// rtl/nios2_ocimem_arbiter.sv - arbitrates the single-port OCI RAM between JTAG and Avalon debug slave
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                debugack,
    input  logic                jcmd_valid,
    input  logic                jcmd_setaddr,
    input  logic                jcmd_write,
    input  logic [ADDR_W-1:0]   jcmd_addr,
    input  logic [DATA_W-1:0]   jcmd_wdata,
    output logic                jcmd_ready,
    output logic                jrsp_valid,
    output logic [DATA_W-1:0]   jrsp_rdata,
    output logic                jerr,
    input  logic [ADDR_W-1:0]   av_address,
    input  logic                av_read,
    input  logic                av_write,
    input  logic [DATA_W-1:0]   av_writedata,
    input  logic [DATA_W/8-1:0] av_byteenable,
    output logic [DATA_W-1:0]   av_readdata,
    output logic                av_waitrequest,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    state_t            r_state;
    grant_t            r_last;
    logic              r_av_wr;
    logic              r_wait;
    logic              r_jrsp;
    logic [DATA_W-1:0] r_jrdata;

    logic [ADDR_W-1:0]   w_jaddr;
    logic                w_jpend;
    logic                w_jwrite;
    logic [DATA_W-1:0]   w_jwdata;
    logic                w_av_req;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_we;
    logic [DATA_W/8-1:0] w_ram_be;
    logic [DATA_W-1:0]   w_ram_wdata;

    assign w_av_req = av_read | av_write;

    nios2_ocimem_jtag_cmd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_cmd (
        .clk           (clk),
        .reset         (reset),
        .i_cmd_valid   (jcmd_valid),
        .i_cmd_setaddr (jcmd_setaddr),
        .i_cmd_write   (jcmd_write),
        .i_cmd_addr    (jcmd_addr),
        .i_cmd_wdata   (jcmd_wdata),
        .i_consume     (r_state == ST_J_ACC),
        .o_jaddr       (w_jaddr),
        .o_jpend       (w_jpend),
        .o_write       (w_jwrite),
        .o_wdata       (w_jwdata),
        .o_jerr        (jerr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_last   <= GRANT_AV;
            r_av_wr  <= 1'b0;
            r_wait   <= 1'b1;
            r_jrsp   <= 1'b0;
            r_jrdata <= '0;
        end else begin
            r_wait <= 1'b1;
            r_jrsp <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Ties go to JTAG under debugack, otherwise to whoever lost last time.
                    if (w_jpend && (!w_av_req || debugack || r_last == GRANT_AV)) begin
                        r_state <= ST_J_ACC;
                        r_last  <= GRANT_JTAG;
                        r_jrsp  <= w_jwrite;
                    end else if (w_av_req) begin
                        r_state <= ST_A_ACC;
                        r_last  <= GRANT_AV;
                        r_av_wr <= av_write;
                        r_wait  <= !av_write;
                    end
                end
                ST_J_ACC: begin
                    if (w_jwrite) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_J_RD;
                        r_jrsp  <= 1'b1;
                    end
                end
                ST_J_RD: begin
                    r_jrdata <= ram_rdata;
                    r_state  <= ST_IDLE;
                end
                ST_A_ACC: begin
                    if (r_av_wr) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_A_RD;
                        r_wait  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ram_addr  = '0;
        w_ram_we    = 1'b0;
        w_ram_be    = '0;
        w_ram_wdata = '0;
        case (r_state)
            ST_J_ACC: begin
                w_ram_addr  = w_jaddr;
                w_ram_we    = w_jwrite;
                w_ram_be    = '1;
                w_ram_wdata = w_jwdata;
            end
            ST_A_ACC: begin
                w_ram_addr  = av_address;
                w_ram_we    = r_av_wr;
                w_ram_be    = av_byteenable;
                w_ram_wdata = av_writedata;
            end
            default: ;
        endcase
    end

    // Reset in the commit cycle must suppress both the RAM write and the response pulse.
    assign ram_we         = w_ram_we & ~reset;
    assign jrsp_valid     = r_jrsp & ~reset;
    assign ram_addr       = w_ram_addr;
    assign ram_be         = w_ram_be;
    assign ram_wdata      = w_ram_wdata;
    assign jcmd_ready     = !w_jpend;
    assign jrsp_rdata     = r_jrdata;
    assign av_readdata    = ram_rdata;
    assign av_waitrequest = r_wait;
endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// tb/tb_nios2_ocimem_arbiter.sv - self-checking bench for nios2_ocimem_arbiter
module tb_nios2_ocimem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        debugack;
    logic        jcmd_valid, jcmd_setaddr, jcmd_write;
    logic [7:0]  jcmd_addr;
    logic [31:0] jcmd_wdata;
    logic        jcmd_ready, jrsp_valid, jerr;
    logic [31:0] jrsp_rdata;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios2_ocimem_arbiter dut (
        .clk(clk), .reset(reset), .debugack(debugack),
        .jcmd_valid(jcmd_valid), .jcmd_setaddr(jcmd_setaddr), .jcmd_write(jcmd_write),
        .jcmd_addr(jcmd_addr), .jcmd_wdata(jcmd_wdata), .jcmd_ready(jcmd_ready),
        .jrsp_valid(jrsp_valid), .jrsp_rdata(jrsp_rdata), .jerr(jerr),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [31:0] ram [256];
    logic [31:0] ram_next;
    always @(posedge clk) begin
        ram_next = ram[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram_next[8*b +: 8] = ram_wdata[8*b +: 8];
        if (ram_we) ram[ram_addr] <= ram_next;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, whether we are in the data-return cycle,
    // the JTAG command bookkeeping and a shadow copy of memory.
    int          m_owner = 0;          // 0 none, 1 jtag, 2 avalon
    bit          m_dphase = 0;
    bit          m_last_j = 0;
    bit          m_awr = 0;
    int          m_acc = 0;
    int          m_jaddr = 0;
    bit          m_jpend = 0, m_jwr = 0, m_jerr = 0;
    logic [31:0] m_jwdata = 0, m_jrdata = 0;
    logic [31:0] m_mem [256];
    bit          e_we, e_rsp, e_wait, old_jpend, jr, ar;

    always @(negedge clk) begin
        e_rsp = !reset && m_owner == 1 && (m_dphase || m_jwr);
        e_we  = !reset && !m_dphase && ((m_owner == 1 && m_jwr) || (m_owner == 2 && m_awr));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("jrsp_valid", 32'(jrsp_valid), 32'(e_rsp));
        if (!reset) begin
            e_wait = !(m_owner == 2 && (m_dphase || m_awr));
            chk("av_waitrequest", 32'(av_waitrequest), 32'(e_wait));
            chk("jcmd_ready", 32'(jcmd_ready), 32'(!m_jpend));
            chk("jerr", 32'(jerr), 32'(m_jerr));
            chk("jrsp_rdata", jrsp_rdata, m_jrdata);
            if (m_owner == 0) chk("ram_addr_idle", 32'(ram_addr), 32'h0);
            else if (!m_dphase) begin
                chk("ram_addr", 32'(ram_addr), (m_owner == 1) ? 32'(m_jaddr % 256) : 32'(av_address));
                if (e_we) begin
                    chk("ram_be", 32'(ram_be), (m_owner == 1) ? 32'hF : 32'(av_byteenable));
                    chk("ram_wdata", ram_wdata, (m_owner == 1) ? m_jwdata : av_writedata);
                end
            end
            if (m_owner == 2 && m_dphase) chk("av_readdata", av_readdata, m_mem[m_acc]);
        end
        if (reset) begin
            m_owner = 0; m_dphase = 0; m_last_j = 0; m_jaddr = 0;
            m_jpend = 0; m_jerr = 0; m_jrdata = 0;
        end else begin
            old_jpend = m_jpend;
            if (m_owner == 0) begin
                jr = old_jpend;
                ar = av_read || av_write;
                if (jr && (!ar || debugack || !m_last_j)) begin
                    m_owner = 1; m_last_j = 1;
                end else if (ar) begin
                    m_owner = 2; m_last_j = 0; m_awr = av_write;
                end
            end else if (m_owner == 1 && !m_dphase) begin
                m_jpend = 0;
                m_acc = m_jaddr;
                if (m_jwr) begin m_mem[m_jaddr] = m_jwdata; m_owner = 0; end
                else m_dphase = 1;
                m_jaddr = (m_jaddr + 1) % 256;
            end else if (m_owner == 1) begin
                m_jrdata = m_mem[m_acc]; m_owner = 0; m_dphase = 0;
            end else if (!m_dphase) begin
                if (m_awr) begin
                    for (int b = 0; b < 4; b++)
                        if (av_byteenable[b]) m_mem[av_address][8*b +: 8] = av_writedata[8*b +: 8];
                    m_owner = 0;
                end else begin
                    m_dphase = 1; m_acc = int'(av_address);
                end
            end else begin
                m_owner = 0; m_dphase = 0;
            end
            if (jcmd_valid && jcmd_setaddr) m_jaddr = int'(jcmd_addr);
            else if (jcmd_valid) begin
                if (old_jpend) m_jerr = 1;
                else begin m_jpend = 1; m_jwr = jcmd_write; m_jwdata = jcmd_wdata; end
            end
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask
    task automatic jpulse(input bit sa, input bit wr, input logic [7:0] a, input logic [31:0] d);
        jcmd_valid = 1'b1; jcmd_setaddr = sa; jcmd_write = wr; jcmd_addr = a; jcmd_wdata = d;
    endtask
    task automatic setaddr(input logic [7:0] a);
        cyc(); jpulse(1, 0, a, 32'h0); cyc(); jcmd_valid = 1'b0;
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wait"}, 32'(av_waitrequest), 32'h1);
        chk({tag, "_ready"}, 32'(jcmd_ready), 32'h1);
        chk({tag, "_jerr"}, 32'(jerr), 32'h0);
        chk({tag, "_rsp"}, 32'(jrsp_valid), 32'h0);
        chk({tag, "_rdata"}, jrsp_rdata, 32'h0);
        chk({tag, "_we"}, 32'(ram_we), 32'h0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'h0);
    endtask

    task automatic tie(input bit dbg, input bit jfirst, input logic [31:0] jd, input logic [31:0] ad);
        cyc(); debugack = dbg; jpulse(0, 1, 8'h0, jd);
        cyc(); jcmd_valid = 1'b0; av_write = 1'b1; av_address = 8'h30;
        av_writedata = ad; av_byteenable = 4'hF;
        smp(); chk("tie_c1_wait", 32'(av_waitrequest), 32'h1);
        cyc(); smp();
        chk("tie_first_data", ram_wdata, jfirst ? jd : ad);
        chk("tie_first_we", 32'(ram_we), 32'h1);
        cyc(); if (!jfirst) av_write = 1'b0;
        smp(); chk("tie_gap_we", 32'(ram_we), 32'h0);
        cyc(); smp();
        chk("tie_second_data", ram_wdata, jfirst ? ad : jd);
        chk("tie_second_we", 32'(ram_we), 32'h1);
        cyc(); av_write = 1'b0;
        cyc(); cyc();
    endtask

    int rsp_cnt;
    bit done;

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = 32'h0; m_mem[i] = 32'h0; end
        ram[8'h20] = 32'hCAFE1234; m_mem[8'h20] = 32'hCAFE1234;
        reset = 1'b1; debugack = 1'b0;
        jcmd_valid = 0; jcmd_setaddr = 0; jcmd_write = 0; jcmd_addr = 0; jcmd_wdata = 0;
        av_address = 0; av_read = 0; av_write = 0; av_writedata = 0; av_byteenable = 0;
        repeat (3) cyc();
        reset = 1'b0;
        smp(); chk_reset_vals("rst");

        // JTAG write then read back through the auto-increment address.
        setaddr(8'h10);
        cyc(); jpulse(0, 1, 8'h0, 32'hDEADBEEF);
        cyc(); jcmd_valid = 1'b0; smp(); chk("jw_c1_ready", 32'(jcmd_ready), 32'h0);
        cyc(); smp();
        chk("jw_c2_we", 32'(ram_we), 32'h1);
        chk("jw_c2_addr", 32'(ram_addr), 32'h10);
        chk("jw_c2_data", ram_wdata, 32'hDEADBEEF);
        chk("jw_c2_rsp", 32'(jrsp_valid), 32'h1);
        cyc(); smp(); chk("jw_c3_ready", 32'(jcmd_ready), 32'h1);
        setaddr(8'h10);
        cyc(); jpulse(0, 0, 8'h0, 32'h0);
        cyc(); jcmd_valid = 1'b0;
        cyc();
        cyc(); smp(); chk("jr_c3_rsp", 32'(jrsp_valid), 32'h1);
        cyc(); smp();
        chk("jr_c4_rdata", jrsp_rdata, 32'hDEADBEEF);
        chk("jr_c4_rsp", 32'(jrsp_valid), 32'h0);
        chk("model_jaddr_11", 32'(m_jaddr), 32'h11);

        // Address wrap from 0xFF to 0x00.
        setaddr(8'hFF);
        cyc(); jpulse(0, 1, 8'h0, 32'hA1A1A1A1); cyc(); jcmd_valid = 1'b0; repeat (3) cyc();
        cyc(); jpulse(0, 1, 8'h0, 32'hB2B2B2B2); cyc(); jcmd_valid = 1'b0; repeat (3) cyc();
        smp();
        chk("wrap_ram_ff", ram[8'hFF], 32'hA1A1A1A1);
        chk("wrap_ram_00", ram[8'h00], 32'hB2B2B2B2);
        chk("wrap_model_00", m_mem[0], 32'hB2B2B2B2);
        chk("wrap_model_jaddr", 32'(m_jaddr), 32'h1);

        // Avalon partial write then read.
        cyc(); av_write = 1; av_address = 8'h20; av_writedata = 32'h5; av_byteenable = 4'b0011;
        smp(); chk("aw_c0_wait", 32'(av_waitrequest), 32'h1);
        cyc(); smp(); chk("aw_c1_wait", 32'(av_waitrequest), 32'h0);
        chk("aw_c1_be", 32'(ram_be), 32'h3);
        cyc(); av_write = 0; smp(); chk("aw_c2_wait", 32'(av_waitrequest), 32'h1);
        cyc(); av_read = 1; smp(); chk("ar_c0_wait", 32'(av_waitrequest), 32'h1);
        cyc(); smp(); chk("ar_c1_wait", 32'(av_waitrequest), 32'h1);
        cyc(); smp(); chk("ar_c2_wait", 32'(av_waitrequest), 32'h0);
        chk("ar_c2_data", av_readdata, 32'hCAFE0005);
        cyc(); av_read = 0; smp(); chk("ar_c3_wait", 32'(av_waitrequest), 32'h1);

        // Contention: last grant Avalon -> JTAG; after a JTAG-only grant -> Avalon; debugack -> JTAG.
        tie(0, 1, 32'h11110001, 32'h22220001);
        cyc(); jpulse(0, 1, 8'h0, 32'h11110002); cyc(); jcmd_valid = 1'b0; repeat (3) cyc();
        tie(0, 0, 32'h11110003, 32'h22220003);
        tie(1, 1, 32'h11110004, 32'h22220004);
        debugack = 1'b0;

        // Second read while one is pending is dropped and latches jerr.
        cyc(); jpulse(0, 0, 8'h0, 32'h0);
        cyc(); jpulse(0, 0, 8'h0, 32'h0); smp(); chk("drop_c1_ready", 32'(jcmd_ready), 32'h0);
        cyc(); jcmd_valid = 1'b0; smp(); chk("drop_jerr", 32'(jerr), 32'h1);
        rsp_cnt = int'(jrsp_valid);
        repeat (8) begin cyc(); smp(); rsp_cnt += int'(jrsp_valid); end
        chk("drop_rsp_count", 32'(rsp_cnt), 32'h1);
        chk("drop_jerr_sticky", 32'(jerr), 32'h1);

        // Reset in the commit cycle of a JTAG write.
        setaddr(8'h50);
        cyc(); jpulse(0, 1, 8'h0, 32'h77777777);
        cyc(); jcmd_valid = 1'b0;
        cyc(); reset = 1'b1; smp();
        chk("rstacc_we", 32'(ram_we), 32'h0);
        chk("rstacc_rsp", 32'(jrsp_valid), 32'h0);
        cyc(); reset = 1'b0; smp(); chk_reset_vals("rstacc");
        cyc(); smp(); chk("rstacc_ram50", ram[8'h50], 32'h0);

        // Randomised traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            smp(); done = (av_read || av_write) && !av_waitrequest;
            cyc();
            if (!(av_read || av_write) || done) begin
                av_read = 0; av_write = 0;
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) av_write = 1; else av_read = 1;
                    av_address = 8'($urandom); av_writedata = $urandom;
                    av_byteenable = 4'($urandom);
                end
            end
            jcmd_valid   = ($urandom_range(0, 4) == 0);
            jcmd_setaddr = ($urandom_range(0, 3) == 0);
            jcmd_write   = 1'($urandom);
            jcmd_addr    = 8'($urandom);
            jcmd_wdata   = $urandom;
            if ($urandom_range(0, 49) == 0) debugack = !debugack;
        end
        cyc(); av_read = 0; av_write = 0; jcmd_valid = 0;
        repeat (4) cyc();
        smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
